// File: rtl/ysyx_24110006_arbiter.sv
// Fixed-priority AXI4 arbiter: LSU write > LSU read > IFU read onto one
// memory master port, with a sticky response-timeout flag.
module ysyx_24110006_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd4095
) (
   input  logic        i_clock,
   input  logic        i_reset,

   input  logic [31:0] i_ifu_araddr,
   input  logic        i_ifu_arvalid,
   input  logic [3:0]  i_ifu_arid,
   input  logic [7:0]  i_ifu_arlen,
   input  logic [2:0]  i_ifu_arsize,
   input  logic [1:0]  i_ifu_arburst,
   output logic        o_ifu_arready,
   output logic [31:0] o_ifu_rdata,
   output logic [1:0]  o_ifu_rresp,
   output logic        o_ifu_rvalid,
   output logic        o_ifu_rlast,
   output logic [3:0]  o_ifu_rid,
   input  logic        i_ifu_rready,

   input  logic [31:0] i_lsu_araddr,
   input  logic        i_lsu_arvalid,
   input  logic [3:0]  i_lsu_arid,
   input  logic [7:0]  i_lsu_arlen,
   input  logic [2:0]  i_lsu_arsize,
   input  logic [1:0]  i_lsu_arburst,
   output logic        o_lsu_arready,
   output logic [31:0] o_lsu_rdata,
   output logic [1:0]  o_lsu_rresp,
   output logic        o_lsu_rvalid,
   output logic        o_lsu_rlast,
   output logic [3:0]  o_lsu_rid,
   input  logic        i_lsu_rready,

   input  logic [31:0] i_lsu_awaddr,
   input  logic        i_lsu_awvalid,
   input  logic [3:0]  i_lsu_awid,
   input  logic [7:0]  i_lsu_awlen,
   input  logic [2:0]  i_lsu_awsize,
   input  logic [1:0]  i_lsu_awburst,
   output logic        o_lsu_awready,
   input  logic [31:0] i_lsu_wdata,
   input  logic [3:0]  i_lsu_wstrb,
   input  logic        i_lsu_wvalid,
   input  logic        i_lsu_wlast,
   output logic        o_lsu_wready,
   output logic [1:0]  o_lsu_bresp,
   output logic        o_lsu_bvalid,
   output logic [3:0]  o_lsu_bid,
   input  logic        i_lsu_bready,

   output logic [31:0] o_axi_araddr,
   output logic        o_axi_arvalid,
   output logic [3:0]  o_axi_arid,
   output logic [7:0]  o_axi_arlen,
   output logic [2:0]  o_axi_arsize,
   output logic [1:0]  o_axi_arburst,
   input  logic        i_axi_arready,
   input  logic [31:0] i_axi_rdata,
   input  logic [1:0]  i_axi_rresp,
   input  logic        i_axi_rvalid,
   input  logic        i_axi_rlast,
   input  logic [3:0]  i_axi_rid,
   output logic        o_axi_rready,
   output logic [31:0] o_axi_awaddr,
   output logic        o_axi_awvalid,
   output logic [3:0]  o_axi_awid,
   output logic [7:0]  o_axi_awlen,
   output logic [2:0]  o_axi_awsize,
   output logic [1:0]  o_axi_awburst,
   input  logic        i_axi_awready,
   output logic [31:0] o_axi_wdata,
   output logic [3:0]  o_axi_wstrb,
   output logic        o_axi_wvalid,
   output logic        o_axi_wlast,
   input  logic        i_axi_wready,
   input  logic [1:0]  i_axi_bresp,
   input  logic        i_axi_bvalid,
   input  logic [3:0]  i_axi_bid,
   output logic        o_axi_bready,

   output logic        o_timeout
);

   typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        lsu_sel;

   // Payloads are steered by state; only the valids/readies are gated.
   assign lsu_sel       = (state_q == LSU_RD);
   assign o_axi_araddr  = lsu_sel ? i_lsu_araddr  : i_ifu_araddr;
   assign o_axi_arid    = lsu_sel ? i_lsu_arid    : i_ifu_arid;
   assign o_axi_arlen   = lsu_sel ? i_lsu_arlen   : i_ifu_arlen;
   assign o_axi_arsize  = lsu_sel ? i_lsu_arsize  : i_ifu_arsize;
   assign o_axi_arburst = lsu_sel ? i_lsu_arburst : i_ifu_arburst;

   assign o_axi_awaddr  = i_lsu_awaddr;
   assign o_axi_awid    = i_lsu_awid;
   assign o_axi_awlen   = i_lsu_awlen;
   assign o_axi_awsize  = i_lsu_awsize;
   assign o_axi_awburst = i_lsu_awburst;
   assign o_axi_wdata   = i_lsu_wdata;
   assign o_axi_wstrb   = i_lsu_wstrb;
   assign o_axi_wlast   = i_lsu_wlast;

   assign o_ifu_rdata = i_axi_rdata;
   assign o_ifu_rresp = i_axi_rresp;
   assign o_ifu_rlast = i_axi_rlast;
   assign o_ifu_rid   = i_axi_rid;
   assign o_lsu_rdata = i_axi_rdata;
   assign o_lsu_rresp = i_axi_rresp;
   assign o_lsu_rlast = i_axi_rlast;
   assign o_lsu_rid   = i_axi_rid;
   assign o_lsu_bresp = i_axi_bresp;
   assign o_lsu_bid   = i_axi_bid;

   assign o_timeout = timeout_q;

   always_comb begin
      o_ifu_arready = 1'b0;
      o_ifu_rvalid  = 1'b0;
      o_lsu_arready = 1'b0;
      o_lsu_rvalid  = 1'b0;
      o_lsu_awready = 1'b0;
      o_lsu_wready  = 1'b0;
      o_lsu_bvalid  = 1'b0;
      o_axi_arvalid = 1'b0;
      o_axi_rready  = 1'b0;
      o_axi_awvalid = 1'b0;
      o_axi_wvalid  = 1'b0;
      o_axi_bready  = 1'b0;
      unique case (state_q)
         IDLE: ;
         IFU_RD: begin
            o_axi_arvalid = i_ifu_arvalid;
            o_ifu_arready = i_axi_arready;
            o_ifu_rvalid  = i_axi_rvalid;
            o_axi_rready  = i_ifu_rready;
         end
         LSU_RD: begin
            o_axi_arvalid = i_lsu_arvalid;
            o_lsu_arready = i_axi_arready;
            o_lsu_rvalid  = i_axi_rvalid;
            o_axi_rready  = i_lsu_rready;
         end
         LSU_WR: begin
            o_axi_awvalid = i_lsu_awvalid;
            o_lsu_awready = i_axi_awready;
            o_axi_wvalid  = i_lsu_wvalid;
            o_lsu_wready  = i_axi_wready;
            o_lsu_bvalid  = i_axi_bvalid;
            o_axi_bready  = i_lsu_bready;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            priority case (1'b1)
               i_lsu_awvalid: state_d = LSU_WR;
               i_lsu_arvalid: state_d = LSU_RD;
               i_ifu_arvalid: state_d = IFU_RD;
               default:       state_d = IDLE;
            endcase
         end
         IFU_RD, LSU_RD: begin
            if (i_axi_rvalid && o_axi_rready && i_axi_rlast)
               state_d = IDLE;
         end
         LSU_WR: begin
            if (i_axi_bvalid && i_lsu_bready)
               state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)
         cnt_d = 16'd0;
      else if (cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;
      timeout_d = timeout_q |
                  ((state_q != IDLE) && (cnt_d == TIMEOUT));
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_arbiter.sv
// Bench for ysyx_24110006_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_ysyx_24110006_arbiter;

   localparam logic [15:0] TMO = 16'd16;
   localparam int NONE = 0, IFU = 1, LRD = 2, LWR = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [31:0] ifu_araddr = '0;
   logic        ifu_arvalid = 0;
   logic [3:0]  ifu_arid = '0;
   logic [7:0]  ifu_arlen = '0;
   logic [2:0]  ifu_arsize = '0;
   logic [1:0]  ifu_arburst = '0;
   logic        ifu_rready = 0;
   logic [31:0] lsu_araddr = '0;
   logic        lsu_arvalid = 0;
   logic [3:0]  lsu_arid = '0;
   logic [7:0]  lsu_arlen = '0;
   logic [2:0]  lsu_arsize = '0;
   logic [1:0]  lsu_arburst = '0;
   logic        lsu_rready = 0;
   logic [31:0] lsu_awaddr = '0;
   logic        lsu_awvalid = 0;
   logic [3:0]  lsu_awid = '0;
   logic [7:0]  lsu_awlen = '0;
   logic [2:0]  lsu_awsize = '0;
   logic [1:0]  lsu_awburst = '0;
   logic [31:0] lsu_wdata = '0;
   logic [3:0]  lsu_wstrb = '0;
   logic        lsu_wvalid = 0;
   logic        lsu_wlast = 0;
   logic        lsu_bready = 0;
   logic        axi_arready = 0;
   logic [31:0] axi_rdata = '0;
   logic [1:0]  axi_rresp = '0;
   logic        axi_rvalid = 0;
   logic        axi_rlast = 0;
   logic [3:0]  axi_rid = '0;
   logic        axi_awready = 0;
   logic        axi_wready = 0;
   logic [1:0]  axi_bresp = '0;
   logic        axi_bvalid = 0;
   logic [3:0]  axi_bid = '0;

   logic        o_ifu_arready, o_ifu_rvalid, o_ifu_rlast;
   logic [31:0] o_ifu_rdata;
   logic [1:0]  o_ifu_rresp;
   logic [3:0]  o_ifu_rid;
   logic        o_lsu_arready, o_lsu_rvalid, o_lsu_rlast;
   logic [31:0] o_lsu_rdata;
   logic [1:0]  o_lsu_rresp;
   logic [3:0]  o_lsu_rid;
   logic        o_lsu_awready, o_lsu_wready, o_lsu_bvalid;
   logic [1:0]  o_lsu_bresp;
   logic [3:0]  o_lsu_bid;
   logic [31:0] o_axi_araddr, o_axi_awaddr, o_axi_wdata;
   logic        o_axi_arvalid, o_axi_rready, o_axi_awvalid;
   logic        o_axi_wvalid, o_axi_wlast, o_axi_bready;
   logic [3:0]  o_axi_arid, o_axi_awid, o_axi_wstrb;
   logic [7:0]  o_axi_arlen, o_axi_awlen;
   logic [2:0]  o_axi_arsize, o_axi_awsize;
   logic [1:0]  o_axi_arburst, o_axi_awburst;
   logic        o_timeout;

   int n_tests = 0;
   int n_fail = 0;

   ysyx_24110006_arbiter #(.TIMEOUT(TMO)) dut (
      .i_clock(clk), .i_reset(rst_n),
      .i_ifu_araddr(ifu_araddr), .i_ifu_arvalid(ifu_arvalid),
      .i_ifu_arid(ifu_arid), .i_ifu_arlen(ifu_arlen),
      .i_ifu_arsize(ifu_arsize), .i_ifu_arburst(ifu_arburst),
      .o_ifu_arready(o_ifu_arready), .o_ifu_rdata(o_ifu_rdata),
      .o_ifu_rresp(o_ifu_rresp), .o_ifu_rvalid(o_ifu_rvalid),
      .o_ifu_rlast(o_ifu_rlast), .o_ifu_rid(o_ifu_rid),
      .i_ifu_rready(ifu_rready),
      .i_lsu_araddr(lsu_araddr), .i_lsu_arvalid(lsu_arvalid),
      .i_lsu_arid(lsu_arid), .i_lsu_arlen(lsu_arlen),
      .i_lsu_arsize(lsu_arsize), .i_lsu_arburst(lsu_arburst),
      .o_lsu_arready(o_lsu_arready), .o_lsu_rdata(o_lsu_rdata),
      .o_lsu_rresp(o_lsu_rresp), .o_lsu_rvalid(o_lsu_rvalid),
      .o_lsu_rlast(o_lsu_rlast), .o_lsu_rid(o_lsu_rid),
      .i_lsu_rready(lsu_rready),
      .i_lsu_awaddr(lsu_awaddr), .i_lsu_awvalid(lsu_awvalid),
      .i_lsu_awid(lsu_awid), .i_lsu_awlen(lsu_awlen),
      .i_lsu_awsize(lsu_awsize), .i_lsu_awburst(lsu_awburst),
      .o_lsu_awready(o_lsu_awready), .i_lsu_wdata(lsu_wdata),
      .i_lsu_wstrb(lsu_wstrb), .i_lsu_wvalid(lsu_wvalid),
      .i_lsu_wlast(lsu_wlast), .o_lsu_wready(o_lsu_wready),
      .o_lsu_bresp(o_lsu_bresp), .o_lsu_bvalid(o_lsu_bvalid),
      .o_lsu_bid(o_lsu_bid), .i_lsu_bready(lsu_bready),
      .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid),
      .o_axi_arid(o_axi_arid), .o_axi_arlen(o_axi_arlen),
      .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
      .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata),
      .i_axi_rresp(axi_rresp), .i_axi_rvalid(axi_rvalid),
      .i_axi_rlast(axi_rlast), .i_axi_rid(axi_rid),
      .o_axi_rready(o_axi_rready),
      .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid),
      .o_axi_awid(o_axi_awid), .o_axi_awlen(o_axi_awlen),
      .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
      .i_axi_awready(axi_awready), .o_axi_wdata(o_axi_wdata),
      .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
      .o_axi_wlast(o_axi_wlast), .i_axi_wready(axi_wready),
      .i_axi_bresp(axi_bresp), .i_axi_bvalid(axi_bvalid),
      .i_axi_bid(axi_bid), .o_axi_bready(o_axi_bready),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural model: who owns the bus, cycles waited, sticky timeout.
   int owner = NONE;
   int waited = 0;
   bit tmo = 0;

   always @(posedge clk or negedge rst_n) begin
      int nxt, w;
      bit done;
      if (!rst_n) begin
         owner  <= NONE;
         waited <= 0;
         tmo    <= 0;
      end else if (owner == NONE) begin
         nxt = NONE;
         if (lsu_awvalid)      nxt = LWR;
         else if (lsu_arvalid) nxt = LRD;
         else if (ifu_arvalid) nxt = IFU;
         owner  <= nxt;
         waited <= 0;
      end else begin
         if (owner == LWR)
            done = axi_bvalid && lsu_bready;
         else
            done = axi_rvalid && axi_rlast &&
                   (owner == IFU ? ifu_rready : lsu_rready);
         w = (waited < 65535) ? waited + 1 : waited;
         waited <= w;
         if (w == int'(TMO)) tmo <= 1;
         if (done) owner <= NONE;
      end
   end

   always @(negedge clk) begin
      bit gi, gl, gw, arv;
      logic [63:0] arp;
      gi  = (owner == IFU);
      gl  = (owner == LRD);
      gw  = (owner == LWR);
      arv = (gi && ifu_arvalid) || (gl && lsu_arvalid);
      chk("ifu_hs", {o_ifu_arready, o_ifu_rvalid},
          {gi && axi_arready, gi && axi_rvalid});
      chk("lsu_hs", {o_lsu_arready, o_lsu_rvalid, o_lsu_awready,
                     o_lsu_wready, o_lsu_bvalid},
          {gl && axi_arready, gl && axi_rvalid, gw && axi_awready,
           gw && axi_wready, gw && axi_bvalid});
      chk("axi_hs", {o_axi_arvalid, o_axi_rready, o_axi_awvalid,
                     o_axi_wvalid, o_axi_bready},
          {arv, (gi && ifu_rready) || (gl && lsu_rready),
           gw && lsu_awvalid, gw && lsu_wvalid, gw && lsu_bready});
      chk("timeout", 64'(o_timeout), 64'(tmo));
      if (arv) begin
         arp = gl ? {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize,
                     lsu_arburst}
                  : {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize,
                     ifu_arburst};
         chk("ar_payload", {o_axi_araddr, o_axi_arid, o_axi_arlen,
                            o_axi_arsize, o_axi_arburst}, arp);
      end
      if (gi && axi_rvalid)
         chk("ifu_r", {o_ifu_rdata, o_ifu_rresp, o_ifu_rlast, o_ifu_rid},
             {axi_rdata, axi_rresp, axi_rlast, axi_rid});
      if (gl && axi_rvalid)
         chk("lsu_r", {o_lsu_rdata, o_lsu_rresp, o_lsu_rlast, o_lsu_rid},
             {axi_rdata, axi_rresp, axi_rlast, axi_rid});
      if (gw && lsu_awvalid)
         chk("aw_payload", {o_axi_awaddr, o_axi_awid, o_axi_awlen,
                            o_axi_awsize, o_axi_awburst},
             {lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst});
      if (gw && lsu_wvalid)
         chk("w_payload", {o_axi_wdata, o_axi_wstrb, o_axi_wlast},
             {lsu_wdata, lsu_wstrb, lsu_wlast});
      if (gw && axi_bvalid)
         chk("lsu_b", {o_lsu_bresp, o_lsu_bid}, {axi_bresp, axi_bid});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ifu_arvalid = 0; ifu_rready = 0; lsu_arvalid = 0; lsu_rready = 0;
      lsu_awvalid = 0; lsu_wvalid = 0; lsu_wlast = 0; lsu_bready = 0;
      axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 0;
      clear_inputs();
      tick();
      rst_n = 1;
   endtask

   initial begin
      clear_inputs();
      repeat (2) tick();
      neg();
      chk("reset_state", {o_timeout, o_axi_arvalid, o_axi_awvalid,
                          o_axi_wvalid, o_axi_rready, o_axi_bready,
                          o_ifu_rvalid, o_lsu_bvalid}, 64'd0);
      tick();
      rst_n = 1;

      // IFU read alone
      ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; ifu_rready = 1;
      tick();
      neg();
      chk("ifu_ar_fwd", {o_axi_arvalid, o_axi_araddr},
          {1'b1, 32'h8000_0000});
      chk("ifu_arready_wait", 64'(o_ifu_arready), 64'd0);
      tick();
      axi_arready = 1;
      neg();
      chk("ifu_arready", 64'(o_ifu_arready), 64'd1);
      tick();
      ifu_arvalid = 0; axi_arready = 0;
      axi_rvalid = 1; axi_rdata = 32'h0000_0413; axi_rlast = 1;
      axi_rresp = 2'b00;
      neg();
      chk("ifu_rdata", {o_ifu_rvalid, o_ifu_rdata, o_ifu_rresp},
          {1'b1, 32'h0000_0413, 2'b00});
      tick();
      axi_rvalid = 0; axi_rlast = 0; ifu_arvalid = 1;
      neg();
      chk("ifu_back_idle", 64'(o_axi_arvalid), 64'd0);
      do_reset();

      // LSU read beats IFU read, then one idle cycle, then IFU
      lsu_araddr = 32'h0000_1000; lsu_arvalid = 1; lsu_rready = 1;
      ifu_araddr = 32'h8000_0004; ifu_arvalid = 1; ifu_rready = 1;
      axi_arready = 1;
      tick();
      neg();
      chk("prio_araddr", 64'(o_axi_araddr), 64'h1000);
      chk("prio_ifu_block", {o_ifu_arready, o_lsu_arready}, 64'b01);
      tick();
      lsu_arvalid = 0; axi_arready = 0; axi_rvalid = 1; axi_rlast = 1;
      axi_rresp = 2'b11;
      neg();
      chk("prio_lsu_r", {o_lsu_rvalid, o_ifu_rvalid, o_lsu_rresp},
          {1'b1, 1'b0, 2'b11});
      tick();
      axi_rvalid = 0; axi_rlast = 0;
      neg();
      chk("prio_gap", 64'(o_axi_arvalid), 64'd0);
      tick();
      neg();
      chk("prio_ifu_next", {o_axi_arvalid, o_axi_araddr},
          {1'b1, 32'h8000_0004});
      do_reset();

      // LSU write with SLVERR, losing LSU read held pending
      lsu_awaddr = 32'hA000_03F8; lsu_awvalid = 1;
      lsu_wdata = 32'h41; lsu_wstrb = 4'b0001; lsu_wvalid = 1;
      lsu_wlast = 1; lsu_bready = 1; lsu_arvalid = 1;
      axi_awready = 1; axi_wready = 1;
      tick();
      neg();
      chk("wr_aw", {o_axi_awvalid, o_axi_awaddr}, {1'b1, 32'hA000_03F8});
      chk("wr_w", {o_axi_wvalid, o_axi_wdata, o_axi_wstrb},
          {1'b1, 32'h41, 4'b0001});
      chk("wr_no_ar", {o_axi_arvalid, o_lsu_arready}, 64'd0);
      tick();
      lsu_awvalid = 0; lsu_wvalid = 0; axi_awready = 0; axi_wready = 0;
      axi_bvalid = 1; axi_bresp = 2'b10;
      neg();
      chk("wr_bresp", {o_lsu_bvalid, o_lsu_bresp}, {1'b1, 2'b10});
      tick();
      axi_bvalid = 0;
      neg();
      chk("wr_gap", 64'(o_axi_arvalid), 64'd0);
      tick();
      neg();
      chk("wr_then_rd", 64'(o_axi_arvalid), 64'd1);
      do_reset();

      // Timeout with a silent slave, then late completion
      lsu_arvalid = 1; lsu_rready = 1; axi_arready = 1;
      tick();
      lsu_arvalid = 0; axi_arready = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         neg();
         if (i == 15) chk("tmo_not_yet", 64'(o_timeout), 64'd0);
         if (i == 16) chk("tmo_set", 64'(o_timeout), 64'd1);
      end
      tick();
      axi_rvalid = 1; axi_rlast = 1;
      neg();
      chk("tmo_late_r", {o_lsu_rvalid, o_timeout}, 64'b11);
      tick();
      axi_rvalid = 0; axi_rlast = 0;
      neg();
      chk("tmo_sticky", {o_timeout, o_axi_rready}, 64'b10);
      do_reset();

      // Reset in the middle of an LSU read
      lsu_arvalid = 1; lsu_rready = 1; axi_arready = 1;
      tick();
      tick();
      lsu_arvalid = 0; axi_arready = 0; axi_rvalid = 1;
      neg();
      chk("mid_rd_active", {o_lsu_rvalid, o_axi_rready}, 64'b11);
      #2 rst_n = 0;
      #1;
      chk("mid_rd_reset", {o_lsu_rvalid, o_axi_rready, o_timeout,
                           o_axi_arvalid}, 64'd0);
      axi_rvalid = 0; ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
      tick();
      rst_n = 1;
      neg();
      chk("post_rst_idle", 64'(o_axi_arvalid), 64'd0);
      tick();
      neg();
      chk("post_rst_ifu", {o_axi_arvalid, o_axi_araddr},
          {1'b1, 32'h8000_0100});
      do_reset();

      // Randomized traffic, occasional resets
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst_n = ($urandom_range(0, 99) != 0);
         ifu_araddr  = $urandom;
         ifu_arvalid = ($urandom_range(0, 2) == 0);
         ifu_arid    = 4'($urandom);
         ifu_arlen   = 8'($urandom);
         ifu_arsize  = 3'($urandom);
         ifu_arburst = 2'($urandom);
         ifu_rready  = 1'($urandom);
         lsu_araddr  = $urandom;
         lsu_arvalid = ($urandom_range(0, 3) == 0);
         lsu_arid    = 4'($urandom);
         lsu_arlen   = 8'($urandom);
         lsu_arsize  = 3'($urandom);
         lsu_arburst = 2'($urandom);
         lsu_rready  = 1'($urandom);
         lsu_awaddr  = $urandom;
         lsu_awvalid = ($urandom_range(0, 5) == 0);
         lsu_awid    = 4'($urandom);
         lsu_awlen   = 8'($urandom);
         lsu_awsize  = 3'($urandom);
         lsu_awburst = 2'($urandom);
         lsu_wdata   = $urandom;
         lsu_wstrb   = 4'($urandom);
         lsu_wvalid  = 1'($urandom);
         lsu_wlast   = 1'($urandom);
         lsu_bready  = 1'($urandom);
         axi_arready = 1'($urandom);
         axi_rdata   = $urandom;
         axi_rresp   = 2'($urandom);
         axi_rvalid  = 1'($urandom);
         axi_rlast   = ($urandom_range(0, 3) == 0);
         axi_rid     = 4'($urandom);
         axi_awready = 1'($urandom);
         axi_wready  = 1'($urandom);
         axi_bresp   = 2'($urandom);
         axi_bvalid  = ($urandom_range(0, 3) == 0);
         axi_bid     = 4'($urandom);
      end
      tick();
      neg();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
